// File: rtl/rom_dl_router.sv
// ROM download router: decodes data_io bytes into SDRAM port regions, optionally packs
// byte pairs into 16-bit words, queues them and issues one req/ack toggle handshake at a time.
module rom_dl_router #(
   parameter int unsigned          NPORTS    = 2,
   parameter logic [NPORTS*25-1:0] PORT_BASE = {25'h10000, 25'h0},
   parameter logic [NPORTS*25-1:0] PORT_SIZE = {25'h10000, 25'h10000},
   parameter bit                   WORD_PACK = 1'b1,
   parameter int unsigned          DEPTH     = 4,
   parameter logic [7:0]           ROM_INDEX = 8'd0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_downl,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic [NPORTS-1:0] port_req,
   input  logic [NPORTS-1:0] port_ack,
   output logic [22:0]       port_a,
   output logic [1:0]        port_ds,
   output logic [15:0]       port_d,
   output logic              port_we,
   output logic              aux_wr,
   output logic [24:0]       aux_addr,
   output logic [7:0]        aux_dout,
   output logic              busy,
   output logic              overflow,
   output logic              rom_loaded
);
   localparam int SELW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int AW   = $clog2(DEPTH);

   typedef struct packed {
      logic [SELW-1:0] sel;
      logic [22:0]     a;
      logic [1:0]      ds;
      logic [15:0]     d;
   } entry_t;

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   logic            wr_last_q, downl_q, rom_dl_q, loaded_pend_q, rom_loaded_q, overflow_q;
   logic            aux_wr_q;
   logic [24:0]     aux_addr_q;
   logic [7:0]      aux_dout_q;
   logic            stg_v_q, stg_hit_q;
   logic [SELW-1:0] stg_sel_q;
   logic [24:0]     stg_off_q;
   logic [7:0]      stg_b_q;
   logic            hold_v_q, hold_v_d;
   logic [SELW-1:0] hold_sel_q, hold_sel_d;
   logic [24:0]     hold_off_q, hold_off_d;
   logic [7:0]      hold_b_q, hold_b_d;
   logic            pend_v_q, pend_v_d;
   entry_t          pend_e_q;
   logic            flush_q;
   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wp_q, rp_q;
   logic [AW:0]     cnt_q;
   state_t          state_q;
   logic [NPORTS-1:0] port_req_q;
   logic [22:0]     port_a_q;
   logic [1:0]      port_ds_q;
   logic [15:0]     port_d_q;
   logic [SELW-1:0] cur_sel_q;

   logic            accept, rise, fall, dec_hit;
   logic [SELW-1:0] dec_sel;
   logic [24:0]     dec_off;
   logic            push_v, push_ok, drop, pop, fifo_empty, fifo_full;
   entry_t          push_e, lone_e, held_e, pair_e, head;

   assign accept = ioctl_wr & ~wr_last_q & ioctl_downl & (ioctl_index == ROM_INDEX);
   assign rise   = ioctl_downl & ~downl_q;
   assign fall   = ~ioctl_downl & downl_q;

   // Descending scan so the lowest matching port index wins on overlap.
   always_comb begin
      dec_hit = 1'b0;
      dec_sel = '0;
      dec_off = '0;
      for (int i = NPORTS - 1; i >= 0; i--) begin
         if (PORT_SIZE[i*25 +: 25] != 25'd0 &&
             ioctl_addr >= PORT_BASE[i*25 +: 25] &&
             {1'b0, ioctl_addr} < ({1'b0, PORT_BASE[i*25 +: 25]} + {1'b0, PORT_SIZE[i*25 +: 25]})) begin
            dec_hit = 1'b1;
            dec_sel = SELW'(i);
            dec_off = ioctl_addr - PORT_BASE[i*25 +: 25];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_last_q  <= 1'b0;
         aux_wr_q   <= 1'b0;
         aux_addr_q <= '0;
         aux_dout_q <= '0;
         stg_v_q    <= 1'b0;
         stg_hit_q  <= 1'b0;
         stg_sel_q  <= '0;
         stg_off_q  <= '0;
         stg_b_q    <= '0;
      end else begin
         wr_last_q <= ioctl_wr;
         aux_wr_q  <= accept & ~dec_hit;
         if (accept) begin
            aux_addr_q <= ioctl_addr;
            aux_dout_q <= ioctl_dout;
            stg_v_q    <= 1'b1;
            stg_hit_q  <= dec_hit;
            stg_sel_q  <= dec_sel;
            stg_off_q  <= dec_off;
            stg_b_q    <= ioctl_dout;
         end else if (!pend_v_q) begin
            stg_v_q <= 1'b0;
         end
      end
   end

   assign lone_e = '{sel: stg_sel_q, a: stg_off_q[23:1], ds: {stg_off_q[0], ~stg_off_q[0]},
                     d: {stg_b_q, stg_b_q}};
   assign held_e = '{sel: hold_sel_q, a: hold_off_q[23:1], ds: 2'b01, d: {hold_b_q, hold_b_q}};
   assign pair_e = '{sel: hold_sel_q, a: hold_off_q[23:1], ds: 2'b11, d: {stg_b_q, hold_b_q}};

   // A pending second push goes first; the staged byte waits one cycle behind it.
   always_comb begin
      push_v     = 1'b0;
      push_e     = lone_e;
      pend_v_d   = 1'b0;
      hold_v_d   = hold_v_q;
      hold_sel_d = hold_sel_q;
      hold_off_d = hold_off_q;
      hold_b_d   = hold_b_q;
      if (pend_v_q) begin
         push_v = 1'b1;
         push_e = pend_e_q;
      end else if (stg_v_q) begin
         if (!WORD_PACK) begin
            push_v = stg_hit_q;
         end else if (hold_v_q && stg_hit_q && stg_off_q[0] && stg_sel_q == hold_sel_q &&
                      stg_off_q == hold_off_q + 25'd1) begin
            push_v   = 1'b1;
            push_e   = pair_e;
            hold_v_d = 1'b0;
         end else begin
            if (hold_v_q) begin
               push_v   = 1'b1;
               push_e   = held_e;
               hold_v_d = 1'b0;
            end
            if (stg_hit_q) begin
               if (!stg_off_q[0]) begin
                  hold_v_d   = 1'b1;
                  hold_sel_d = stg_sel_q;
                  hold_off_d = stg_off_q;
                  hold_b_d   = stg_b_q;
               end else if (hold_v_q) begin
                  pend_v_d = 1'b1;
               end else begin
                  push_v = 1'b1;
               end
            end
         end
      end else if (flush_q && hold_v_q) begin
         push_v   = 1'b1;
         push_e   = held_e;
         hold_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hold_v_q   <= 1'b0;
         hold_sel_q <= '0;
         hold_off_q <= '0;
         hold_b_q   <= '0;
         pend_v_q   <= 1'b0;
         pend_e_q   <= '0;
         flush_q    <= 1'b0;
      end else begin
         hold_v_q   <= hold_v_d;
         hold_sel_q <= hold_sel_d;
         hold_off_q <= hold_off_d;
         hold_b_q   <= hold_b_d;
         pend_v_q   <= pend_v_d;
         if (pend_v_d) pend_e_q <= lone_e;
         flush_q <= fall | (flush_q & (pend_v_q | stg_v_q));
      end
   end

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
   assign head       = mem_q[rp_q];
   assign pop        = (state_q == S_WAIT) && (port_ack[cur_sel_q] == port_req_q[cur_sel_q]);
   assign push_ok    = push_v & (~fifo_full | pop);
   assign drop       = push_v & fifo_full & ~pop;

   always_ff @(posedge clk_sys) begin
      if (push_ok) mem_q[wp_q] <= push_e;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wp_q <= wp_q + AW'(1);
         if (pop)     rp_q <= rp_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // The head entry stays in the FIFO until acknowledged, so the port outputs hold still in WAIT.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         port_req_q <= '0;
         port_a_q   <= '0;
         port_ds_q  <= '0;
         port_d_q   <= '0;
         cur_sel_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  port_a_q               <= head.a;
                  port_ds_q              <= head.ds;
                  port_d_q               <= head.d;
                  cur_sel_q              <= head.sel;
                  port_req_q[head.sel]   <= ~port_req_q[head.sel];
                  state_q                <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (pop) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = ~fifo_empty | hold_v_q | stg_v_q | pend_v_q | flush_q | (state_q == S_WAIT);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         downl_q       <= 1'b0;
         rom_dl_q      <= 1'b0;
         loaded_pend_q <= 1'b0;
         rom_loaded_q  <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         downl_q <= ioctl_downl;
         if (fall)                                         rom_dl_q <= 1'b0;
         else if (ioctl_downl && ioctl_index == ROM_INDEX) rom_dl_q <= 1'b1;
         if (fall && rom_dl_q) begin
            loaded_pend_q <= 1'b1;
         end else if (loaded_pend_q && !busy) begin
            loaded_pend_q <= 1'b0;
            rom_loaded_q  <= 1'b1;
         end
         if (drop)      overflow_q <= 1'b1;
         else if (rise) overflow_q <= 1'b0;
      end
   end

   assign port_req   = port_req_q;
   assign port_a     = port_a_q;
   assign port_ds    = port_ds_q;
   assign port_d     = port_d_q;
   assign port_we    = downl_q;
   assign aux_wr     = aux_wr_q;
   assign aux_addr   = aux_addr_q;
   assign aux_dout   = aux_dout_q;
   assign overflow   = overflow_q;
   assign rom_loaded = rom_loaded_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: a word-packing instance on index 0 and a byte-mode instance on
// index 1 share the ioctl bus; scoreboards check each request toggle and aux strobe.
module tb_rom_dl_router;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        ioctl_downl, ioctl_wr;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;

   logic [1:0]  port_req_p, port_ack_p, port_ds_p, port_req_b, port_ack_b, port_ds_b;
   logic [22:0] port_a_p, port_a_b;
   logic [15:0] port_d_p, port_d_b;
   logic        port_we_p, aux_wr_p, busy_p, overflow_p, rom_loaded_p;
   logic        port_we_b, aux_wr_b, busy_b, overflow_b, rom_loaded_b;
   logic [24:0] aux_addr_p, aux_addr_b;
   logic [7:0]  aux_dout_p, aux_dout_b;

   logic        hold_p, hold_b;
   int          tests = 0;
   int          fails = 0;

   logic [42:0] exp_p_q[$];
   logic [42:0] exp_b_q[$];
   logic [32:0] exp_aux_q[$];

   always #5 clk = ~clk;

   rom_dl_router #(.WORD_PACK(1'b1), .ROM_INDEX(8'd0)) dut_p (
      .clk_sys(clk), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .port_req(port_req_p), .port_ack(port_ack_p), .port_a(port_a_p), .port_ds(port_ds_p),
      .port_d(port_d_p), .port_we(port_we_p), .aux_wr(aux_wr_p), .aux_addr(aux_addr_p),
      .aux_dout(aux_dout_p), .busy(busy_p), .overflow(overflow_p), .rom_loaded(rom_loaded_p));

   rom_dl_router #(.WORD_PACK(1'b0), .ROM_INDEX(8'd1)) dut_b (
      .clk_sys(clk), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .port_req(port_req_b), .port_ack(port_ack_b), .port_a(port_a_b), .port_ds(port_ds_b),
      .port_d(port_d_b), .port_we(port_we_b), .aux_wr(aux_wr_b), .aux_addr(aux_addr_b),
      .aux_dout(aux_dout_b), .busy(busy_b), .overflow(overflow_b), .rom_loaded(rom_loaded_b));

   function automatic logic [42:0] mk(input logic [1:0] port, input logic [22:0] a,
                                      input logic [1:0] ds, input logic [15:0] d);
      return {port, a, ds, d};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // SDRAM-side responders: acknowledge three cycles after a request unless held.
   initial begin
      int dly;
      port_ack_p = '0;
      dly = 0;
      forever begin
         @(posedge clk); #1;
         if (!reset_n) begin
            port_ack_p = '0;
            dly = 0;
         end else if (port_ack_p != port_req_p && !hold_p) begin
            dly++;
            if (dly == 3) begin port_ack_p = port_req_p; dly = 0; end
         end else dly = 0;
      end
   end

   initial begin
      int dly;
      port_ack_b = '0;
      dly = 0;
      forever begin
         @(posedge clk); #1;
         if (!reset_n) begin
            port_ack_b = '0;
            dly = 0;
         end else if (port_ack_b != port_req_b && !hold_b) begin
            dly++;
            if (dly == 3) begin port_ack_b = port_req_b; dly = 0; end
         end else dly = 0;
      end
   end

   // Monitors: every request toggle and aux strobe is popped against the expected queues.
   logic [1:0]  prev_p = '0, prev_b = '0;
   logic [42:0] got_p, got_b, want_p, want_b;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_p = port_req_p;
      end else begin
         if (port_req_p != prev_p) begin
            got_p = {((port_req_p ^ prev_p) == 2'b10) ? 2'd1 : 2'd0, port_a_p, port_ds_p, port_d_p};
            tests++;
            if (exp_p_q.size() == 0) begin
               fails++;
               $display("FAIL p_port_write: unexpected toggle, got %0h", got_p);
            end else begin
               want_p = exp_p_q.pop_front();
               if (got_p !== want_p || (port_req_p ^ prev_p) == 2'b11) begin
                  fails++;
                  $display("FAIL p_port_write: got %0h expected %0h", got_p, want_p);
               end
            end
         end
         prev_p = port_req_p;
         if (aux_wr_p) begin
            tests++;
            if (exp_aux_q.size() == 0) begin
               fails++;
               $display("FAIL p_aux: unexpected strobe addr %0h data %0h", aux_addr_p, aux_dout_p);
            end else if ({aux_addr_p, aux_dout_p} !== exp_aux_q[0]) begin
               fails++;
               $display("FAIL p_aux: got %0h expected %0h", {aux_addr_p, aux_dout_p}, exp_aux_q[0]);
               void'(exp_aux_q.pop_front());
            end else void'(exp_aux_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_b = port_req_b;
      end else begin
         if (port_req_b != prev_b) begin
            got_b = {((port_req_b ^ prev_b) == 2'b10) ? 2'd1 : 2'd0, port_a_b, port_ds_b, port_d_b};
            tests++;
            if (exp_b_q.size() == 0) begin
               fails++;
               $display("FAIL b_port_write: unexpected toggle, got %0h", got_b);
            end else begin
               want_b = exp_b_q.pop_front();
               if (got_b !== want_b) begin
                  fails++;
                  $display("FAIL b_port_write: got %0h expected %0h", got_b, want_b);
               end
            end
         end
         prev_b = port_req_b;
         if (aux_wr_b) begin
            tests++;
            fails++;
            $display("FAIL b_aux: unexpected strobe addr %0h", aux_addr_b);
         end
      end
   end

   task automatic send_byte(input logic [24:0] a, input logic [7:0] b);
      @(posedge clk); #1;
      ioctl_addr = a;
      ioctl_dout = b;
      ioctl_wr   = 1'b1;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic start_dl(input logic [7:0] idx);
      @(posedge clk); #1;
      ioctl_index = idx;
      ioctl_downl = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic end_dl();
      @(posedge clk); #1;
      ioctl_downl = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; ioctl_downl = 1'b0; ioctl_wr = 1'b0;
      ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
      hold_p = 1'b0; hold_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_port_req", port_req_p, 0);
      check("reset_port_a_ds_d", {port_a_p, port_ds_p, port_d_p}, 0);
      check("reset_flags", {aux_wr_p, busy_p, overflow_p, rom_loaded_p, port_we_p}, 0);
      @(posedge clk); #1 reset_n = 1'b1;

      start_dl(8'd0);
      @(negedge clk);
      check("p_port_we", port_we_p, 1);
      // Pair 0x00/0x01 packs into one word
      exp_p_q.push_back(mk(2'd0, 23'h0, 2'b11, 16'h55AA));
      send_byte(25'h0, 8'hAA);
      send_byte(25'h1, 8'h55);
      // Lone odd byte in port 1's region
      exp_p_q.push_back(mk(2'd1, 23'h1, 2'b10, 16'h3C3C));
      send_byte(25'h10003, 8'h3C);
      // Unmapped byte goes to aux only
      exp_aux_q.push_back({25'h30000, 8'h99});
      send_byte(25'h30000, 8'h99);
      // Broken pairs: held byte flushed alone, then a lone odd byte in the same cycle
      send_byte(25'h4, 8'h11);
      exp_p_q.push_back(mk(2'd0, 23'h2, 2'b01, 16'h1111));
      send_byte(25'h8, 8'h22);
      exp_p_q.push_back(mk(2'd0, 23'h4, 2'b01, 16'h2222));
      exp_p_q.push_back(mk(2'd0, 23'h5, 2'b10, 16'h3333));
      send_byte(25'hB, 8'h33);
      // Region edges
      exp_p_q.push_back(mk(2'd0, 23'h7FFF, 2'b10, 16'h4444));
      send_byte(25'hFFFF, 8'h44);
      send_byte(25'h10000, 8'h5A);
      exp_p_q.push_back(mk(2'd1, 23'h0, 2'b01, 16'h5A5A));
      send_byte(25'h2, 8'h77);
      @(negedge clk);
      check("p_rom_loaded_during_dl", rom_loaded_p, 0);
      exp_p_q.push_back(mk(2'd0, 23'h1, 2'b01, 16'h7777));
      end_dl();
      begin
         int n = 0;
         while (rom_loaded_p !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      end
      check("p_rom_loaded", rom_loaded_p, 1);
      check("p_busy_after_load", busy_p, 0);
      check("p_queue_drained", exp_p_q.size(), 0);
      check("p_aux_drained", exp_aux_q.size(), 0);

      // Byte-mode instance: six bytes against a stalled port, four fit
      start_dl(8'd1);
      @(negedge clk);
      check("b_overflow_start", overflow_b, 0);
      hold_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k < 4)
            exp_b_q.push_back(mk(2'd0, 23'(k >> 1), (k % 2 == 1) ? 2'b10 : 2'b01,
                                 {2{8'(8'hA0 + k)}}));
         send_byte(25'(k), 8'(8'hA0 + k));
      end
      @(negedge clk);
      check("b_overflow_set", overflow_b, 1);
      check("b_busy_stalled", busy_b, 1);
      check("b_one_pending", port_req_b ^ port_ack_b, 2'b01);
      check("p_ignores_index1", busy_p, 0);
      repeat (10) @(posedge clk);
      hold_b = 1'b0;
      begin
         int n = 0;
         while ((busy_b !== 1'b0 || exp_b_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
      end
      check("b_queue_drained", exp_b_q.size(), 0);
      end_dl();
      begin
         int n = 0;
         while (rom_loaded_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      end
      check("b_rom_loaded", rom_loaded_b, 1);
      check("b_overflow_sticky", overflow_b, 1);
      check("p_rom_loaded_sticky", rom_loaded_p, 1);
      start_dl(8'd0);
      @(negedge clk);
      check("b_overflow_cleared", overflow_b, 0);

      // Reset while a request is outstanding
      exp_p_q.push_back(mk(2'd0, 23'h10, 2'b10, 16'h6565));
      hold_p = 1'b1;
      send_byte(25'h21, 8'h65);
      @(negedge clk);
      check("p_pending_before_reset", port_req_p ^ port_ack_p, 2'b01);
      @(posedge clk); #3 reset_n = 1'b0;
      #1;
      check("p_req_async_reset", port_req_p, 0);
      check("p_busy_async_reset", busy_p, 0);
      check("rom_loaded_async_reset", {rom_loaded_p, rom_loaded_b}, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      hold_p = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("p_no_toggle_after_reset", port_req_p, 0);
      check("p_idle_after_reset", busy_p, 0);
      check("p_queue_after_reset", exp_p_q.size(), 0);
      end_dl();
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
